// File: rtl/alu_if.sv
// Operand/result bundle for the dibu ALU: operands and op select flow in,
// result, live flags and registered flags flow back.
interface alu_if;
  logic [7:0] a;
  logic [7:0] b;
  logic [2:0] op;
  logic       flags_en;
  logic [7:0] out;
  logic [7:0] flags;
  logic [7:0] flags_q;

  modport master (
    output a, b, op, flags_en,
    input  out, flags, flags_q
  );

  modport slave (
    input  a, b, op, flags_en,
    output out, flags, flags_q
  );
endinterface

// File: rtl/alu.sv
// 8-bit dibu ALU: combinational result and 000PZONC flags plus a flag register.
// Optional macro ALU_ROTATE_EN turns ops 110/111 into rotates instead of shifts.
module alu (
  input  logic  clk,
  input  logic  rst,
  alu_if.slave  bus
);

  function automatic logic parity_even(input logic [7:0] v);
    return ~(^v);
  endfunction

  logic [8:0] sum_s;
  logic [8:0] diff_s;
  logic [7:0] res_s;
  logic       c_s;
  logic       o_s;
  logic       undef_s;
  logic [7:0] flags_s;
  logic [7:0] flags_q_r;

  assign sum_s  = {1'b0, bus.a} + {1'b0, bus.b};
  assign diff_s = {1'b0, bus.a} - {1'b0, bus.b};

  // Operation decode: result, carry/borrow and signed overflow
  always_comb begin
    res_s   = 8'h00;
    c_s     = 1'b0;
    o_s     = 1'b0;
    undef_s = 1'b0;
    case (bus.op)
      3'b000: begin
        res_s = sum_s[7:0];
        c_s   = sum_s[8];
        o_s   = (bus.a[7] == bus.b[7]) && (sum_s[7] != bus.a[7]);
      end
      3'b001: begin
        res_s = diff_s[7:0];
        c_s   = diff_s[8];
        o_s   = (bus.a[7] != bus.b[7]) && (diff_s[7] != bus.a[7]);
      end
      3'b010: res_s = bus.a & bus.b;
      3'b011: res_s = bus.a | bus.b;
      3'b100: res_s = bus.a ^ bus.b;
      3'b101: res_s = ~bus.a;
`ifdef ALU_ROTATE_EN
      3'b110: begin
        res_s = {bus.a[6:0], bus.a[7]};
        c_s   = bus.a[7];
      end
      3'b111: begin
        res_s = {bus.a[0], bus.a[7:1]};
        c_s   = bus.a[0];
      end
`else
      3'b110: begin
        res_s = {bus.a[6:0], 1'b0};
        c_s   = bus.a[7];
      end
      3'b111: begin
        res_s = {1'b0, bus.a[7:1]};
        c_s   = bus.a[0];
      end
`endif
      default: undef_s = 1'b1;
    endcase
  end

  // Flag vector assembly; an unresolvable op reports a bare Z with P cleared
  always_comb begin
    flags_s = 8'h00;
    if (undef_s) begin
      flags_s = 8'h08;
    end else begin
      flags_s = {3'b000, parity_even(res_s), (res_s == 8'h00), o_s, res_s[7], c_s};
    end
  end

  // Status register holding the flags of the last committed operation
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_q_r <= 8'h00;
    end else if (bus.flags_en) begin
      flags_q_r <= flags_s;
    end else begin
      flags_q_r <= flags_q_r;
    end
  end

  assign bus.out     = res_s;
  assign bus.flags   = flags_s;
  assign bus.flags_q = flags_q_r;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the dibu ALU; expectations follow
// ALU_ROTATE_EN when that macro is defined.
module tb_alu;
  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;

  alu_if bus ();

  alu dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    bus.op = op;
    bus.a  = a;
    bus.b  = b;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    bus.flags_en = 1'b0;
    bus.op       = 3'b000;
    bus.a        = 8'h00;
    bus.b        = 8'h00;
    #1;
    check("reset_flags_q", bus.flags_q, 8'h00);
    tick();
    rst = 1'b0;

    drive(3'b000, 8'h7F, 8'h01);
    check("add_7f_01_out", bus.out, 8'h80);
    check("add_7f_01_flags", bus.flags, 8'h06);
    drive(3'b000, 8'hFF, 8'h01);
    check("add_ff_01_out", bus.out, 8'h00);
    check("add_ff_01_flags", bus.flags, 8'h19);
    drive(3'b000, 8'h80, 8'h80);
    check("add_80_80_flags", bus.flags, 8'h1D);
    drive(3'b001, 8'h05, 8'h05);
    check("sub_05_05_out", bus.out, 8'h00);
    check("sub_05_05_flags", bus.flags, 8'h18);
    drive(3'b001, 8'h00, 8'h01);
    check("sub_00_01_out", bus.out, 8'hFF);
    check("sub_00_01_flags", bus.flags, 8'h13);
    drive(3'b001, 8'h80, 8'h01);
    check("sub_80_01_out", bus.out, 8'h7F);
    check("sub_80_01_flags", bus.flags, 8'h04);
    drive(3'b010, 8'hF0, 8'h3C);
    check("and_out", bus.out, 8'h30);
    check("and_flags", bus.flags, 8'h10);
    drive(3'b011, 8'h01, 8'h02);
    check("or_out", bus.out, 8'h03);
    check("or_flags", bus.flags, 8'h10);
    drive(3'b100, 8'hAA, 8'hAA);
    check("xor_out", bus.out, 8'h00);
    check("xor_flags", bus.flags, 8'h18);
    drive(3'b101, 8'h0F, 8'h55);
    check("not_out", bus.out, 8'hF0);
    check("not_flags", bus.flags, 8'h12);
`ifdef ALU_ROTATE_EN
    drive(3'b110, 8'h81, 8'h00);
    check("rol_out", bus.out, 8'h03);
    check("rol_flags", bus.flags, 8'h11);
    drive(3'b111, 8'h81, 8'h00);
    check("ror_out", bus.out, 8'hC0);
    check("ror_flags", bus.flags, 8'h13);
`else
    drive(3'b110, 8'h81, 8'h00);
    check("shl_out", bus.out, 8'h02);
    check("shl_flags", bus.flags, 8'h01);
    drive(3'b111, 8'h81, 8'h00);
    check("shr_out", bus.out, 8'h40);
    check("shr_flags", bus.flags, 8'h01);
`endif

    // Flag register: hold when disabled, capture when enabled
    drive(3'b000, 8'hFF, 8'h01);
    tick();
    check("flags_q_hold_disabled", bus.flags_q, 8'h00);
    bus.flags_en = 1'b1;
    tick();
    check("flags_q_capture_add", bus.flags_q, 8'h19);
    bus.flags_en = 1'b0;
    drive(3'b101, 8'h0F, 8'h00);
    tick();
    check("flags_q_hold_after", bus.flags_q, 8'h19);
    bus.flags_en = 1'b1;
    tick();
    check("flags_q_capture_not", bus.flags_q, 8'h12);

    // Asynchronous reset mid-cycle wins over flags_en
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_clear", bus.flags_q, 8'h00);
    check("rst_out_unaffected", bus.out, 8'hF0);
    check("rst_flags_unaffected", bus.flags, 8'h12);
    tick();
    check("rst_holds_with_en", bus.flags_q, 8'h00);
    rst = 1'b0;
    tick();
    check("capture_after_release", bus.flags_q, 8'h12);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
